// File: rtl/kyogenrv_avm_pkg.sv
// kyogenrv_avm_pkg: shared state type and defaults for the KyogenRV Avalon-MM bridges
package kyogenrv_avm_pkg;
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} krv_avm_state_t;
  localparam logic [31:0] KRV_AVM_ERR_DATA = 32'hDEAD_BEEF;
  localparam int KRV_AVM_TIMEOUT = 1024;
endpackage

// File: rtl/kyogenrv_avm_timeout.sv
// kyogenrv_avm_timeout: saturating cycle counter flagging an outstanding bus access as dead
module kyogenrv_avm_timeout
  import kyogenrv_avm_pkg::*;
#(
  parameter int LIMIT = KRV_AVM_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en && cnt != W'(LIMIT)) cnt <= cnt + W'(1);
  // LIMIT of 0 keeps the counter parked at 0 and never expires
  assign expired = (LIMIT != 0) && (cnt == W'(LIMIT));
endmodule

// File: rtl/kyogenrv_dmem_avm_bridge.sv
// kyogenrv_dmem_avm_bridge: serialises KyogenRV dmem requests onto a pipelined Avalon-MM master
module kyogenrv_dmem_avm_bridge
  import kyogenrv_avm_pkg::*;
#(
  parameter int          TIMEOUT_CYC = KRV_AVM_TIMEOUT,
  parameter logic [31:0] ERR_DATA    = KRV_AVM_ERR_DATA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r_dmem_data_req,
  input  logic        w_dmem_data_req,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] w_dmem_data,
  input  logic [3:0]  w_dmem_data_byteenable,
  output logic        r_dmem_data_ack,
  output logic [31:0] r_dmem_data,
  output logic        dmem_waitrequest,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        clear_error,
  output logic        bus_error
);
  krv_avm_state_t state, state_n;
  logic done, done_n, expired, set_err;
  logic rd_n, wr_n, ack_n;
  logic [31:0] addr_n, wdata_n, rdata_n;
  logic [3:0] be_n;

  kyogenrv_avm_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clock(clock), .reset(reset), .clear(state == IDLE), .en(state != IDLE), .expired(expired)
  );

  assign dmem_waitrequest = (r_dmem_data_req | w_dmem_data_req) & ~done;

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    ack_n   = 1'b0;
    set_err = 1'b0;
    rd_n    = avm_read;
    wr_n    = avm_write;
    addr_n  = avm_address;
    wdata_n = avm_writedata;
    be_n    = avm_byteenable;
    rdata_n = r_dmem_data;
    case (state)
      IDLE:
        if (!done && r_dmem_data_req) begin
          state_n = RD_CMD;
          rd_n    = 1'b1;
          addr_n  = dmem_addr;
          be_n    = 4'hF;
          set_err = w_dmem_data_req;
        end else if (!done && w_dmem_data_req) begin
          state_n = WR_CMD;
          wr_n    = 1'b1;
          addr_n  = dmem_addr;
          wdata_n = w_dmem_data;
          be_n    = w_dmem_data_byteenable;
        end
      RD_CMD, RD_DATA:
        // real data beats the timeout when both land in the same cycle
        if ((state == RD_DATA || !avm_waitrequest) && avm_readdatavalid) begin
          {rd_n, ack_n, done_n, state_n} = {1'b0, 1'b1, 1'b1, IDLE};
          rdata_n = avm_readdata;
        end else if (expired) begin
          {rd_n, ack_n, done_n, set_err, state_n} = {1'b0, 1'b1, 1'b1, 1'b1, IDLE};
          rdata_n = ERR_DATA;
        end else if (state == RD_CMD && !avm_waitrequest) begin
          rd_n    = 1'b0;
          state_n = RD_DATA;
        end
      WR_CMD:
        if (!avm_waitrequest || expired) begin
          {wr_n, done_n, state_n} = {1'b0, 1'b1, IDLE};
          set_err = avm_waitrequest;
        end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      done            <= 1'b0;
      avm_read        <= 1'b0;
      avm_write       <= 1'b0;
      avm_address     <= '0;
      avm_writedata   <= '0;
      avm_byteenable  <= '0;
      r_dmem_data     <= '0;
      r_dmem_data_ack <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      done            <= done_n;
      avm_read        <= rd_n;
      avm_write       <= wr_n;
      avm_address     <= addr_n;
      avm_writedata   <= wdata_n;
      avm_byteenable  <= be_n;
      r_dmem_data     <= rdata_n;
      r_dmem_data_ack <= ack_n;
      bus_error       <= set_err | (bus_error & ~clear_error);
    end
endmodule

// File: tb/tb_kyogenrv_dmem_avm_bridge.sv
// tb_kyogenrv_dmem_avm_bridge: directed and randomized checks of the dmem Avalon bridge
module tb_kyogenrv_dmem_avm_bridge;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clock = 1'b0, reset = 1'b0;
  logic r_req = 1'b0, w_req = 1'b0, clear_error = 1'b0;
  logic [31:0] dmem_addr = '0, w_dmem_data = '0, avm_readdata = '0;
  logic [3:0] w_be = '0;
  logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic r_dmem_data_ack, dmem_waitrequest, avm_read, avm_write, bus_error;
  logic [31:0] r_dmem_data, avm_address, avm_writedata;
  logic [3:0] avm_byteenable;

  int total = 0, bad = 0;
  logic err_m = 1'b0;
  logic [31:0] last_rd = '0;

  kyogenrv_dmem_avm_bridge #(.TIMEOUT_CYC(TO), .ERR_DATA(ERR)) dut (
    .clock(clock), .reset(reset),
    .r_dmem_data_req(r_req), .w_dmem_data_req(w_req),
    .dmem_addr(dmem_addr), .w_dmem_data(w_dmem_data), .w_dmem_data_byteenable(w_be),
    .r_dmem_data_ack(r_dmem_data_ack), .r_dmem_data(r_dmem_data),
    .dmem_waitrequest(dmem_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .clear_error(clear_error), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle c counts from the request cycle (c=0). Slave stalls for w cycles, then
  // data arrives d cycles after the command is taken; a dead slave times out at c=TO+1.
  task automatic do_read(input logic [31:0] a, input logic [31:0] data, input int w,
                         input int d, input bit both);
    int tc = TO + 1;
    int nc = 1 + w + d;
    bit tmo = (nc >= tc);
    int ack_c = tmo ? tc + 1 : nc + 1;
    int rd_end = (1 + w < tc) ? 1 + w : tc;
    logic [31:0] exp_d = tmo ? ERR : data;
    step();
    r_req = 1'b1; w_req = both; dmem_addr = a; w_dmem_data = $urandom; w_be = 4'($urandom);
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    #1;
    chk("rd_wait_c0", dmem_waitrequest, 1);
    chk("rd_read_c0", avm_read, 0);
    chk("rd_err_c0", bus_error, err_m);
    for (int c = 1; c <= ack_c; c++) begin
      step();
      avm_waitrequest = (c <= w);
      avm_readdatavalid = !tmo && (c == nc);
      avm_readdata = (c == nc) ? data : $urandom;
      #1;
      chk("rd_avm_read", avm_read, c <= rd_end);
      chk("rd_avm_write", avm_write, 0);
      chk("rd_ack", r_dmem_data_ack, c == ack_c);
      chk("rd_waitreq", dmem_waitrequest, c != ack_c);
      if (c <= rd_end) begin
        chk("rd_addr", avm_address, a);
        chk("rd_be", avm_byteenable, 4'hF);
      end
    end
    err_m = err_m | tmo | both;
    last_rd = exp_d;
    chk("rd_data", r_dmem_data, exp_d);
    chk("rd_err", bus_error, err_m);
    r_req = 1'b0; w_req = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be,
                          input int w);
    int tc = TO + 1;
    bit tmo = (1 + w >= tc);
    int done_c = tmo ? tc + 1 : 2 + w;
    int wr_end = tmo ? tc : 1 + w;
    step();
    w_req = 1'b1; dmem_addr = a; w_dmem_data = data; w_be = be;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    #1;
    chk("wr_wait_c0", dmem_waitrequest, 1);
    chk("wr_write_c0", avm_write, 0);
    for (int c = 1; c <= done_c; c++) begin
      step();
      avm_waitrequest = (c <= w);
      #1;
      chk("wr_avm_write", avm_write, c <= wr_end);
      chk("wr_avm_read", avm_read, 0);
      chk("wr_ack", r_dmem_data_ack, 0);
      chk("wr_waitreq", dmem_waitrequest, c != done_c);
      if (c <= wr_end) begin
        chk("wr_addr", avm_address, a);
        chk("wr_data", avm_writedata, data);
        chk("wr_be", avm_byteenable, be);
      end
    end
    err_m = err_m | tmo;
    chk("wr_rdata_hold", r_dmem_data, last_rd);
    chk("wr_err", bus_error, err_m);
    w_req = 1'b0; avm_waitrequest = 1'b0;
  endtask

  task automatic do_clear();
    step();
    clear_error = 1'b1;
    step();
    clear_error = 1'b0;
    #1;
    err_m = 1'b0;
    chk("err_cleared", bus_error, 0);
  endtask

  initial begin
    // reset state, with the stall output following the request inputs
    #2;
    r_req = 1'b1;
    #1;
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_ack", r_dmem_data_ack, 0);
    chk("rst_err", bus_error, 0);
    chk("rst_rdata", r_dmem_data, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_be", avm_byteenable, 0);
    chk("rst_waitreq_req", dmem_waitrequest, 1);
    r_req = 1'b0;
    #1;
    chk("rst_waitreq_idle", dmem_waitrequest, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    do_read(32'h100, 32'h1234_5678, 0, 1, 1'b0);
    do_write(32'h200, 32'hA5A5_A5A5, 4'b0011, 3);
    do_read(32'h300, 32'hCAFE_F00D, 2, 0, 1'b0);

    // dead slave after command acceptance, then a late response must be ignored
    do_read(32'h400, 32'h0, 0, 1000, 1'b0);
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1111_2222;
    step();
    avm_readdatavalid = 1'b0;
    #1;
    chk("late_rdv_ack", r_dmem_data_ack, 0);
    chk("late_rdv_data", r_dmem_data, ERR);
    chk("late_rdv_err", bus_error, 1);
    do_clear();

    do_read(32'h500, 32'h0, 1000, 0, 1'b0);
    do_clear();
    do_write(32'h600, 32'h0BAD_CAFE, 4'hC, 1000);
    do_clear();
    do_read(32'h700, 32'h7777_0001, 0, 2, 1'b1);
    do_clear();

    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 9));
      int w = int'($urandom_range(0, 3));
      int d = int'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      logic [31:0] v = $urandom;
      if (kind < 5) do_read(a, v, w, d, 1'b0);
      else if (kind < 9) do_write(a, v, 4'($urandom_range(1, 15)), w);
      else do_read(a, v, w, d, 1'b1);
      if (err_m && $urandom_range(0, 1) == 1) do_clear();
    end

    // reset while a read command is stalled drops avm_read without a clock edge
    step();
    r_req = 1'b1; dmem_addr = 32'h800; avm_waitrequest = 1'b1;
    step();
    step();
    #1;
    chk("mid_read_active", avm_read, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_read", avm_read, 0);
    chk("mid_rst_addr", avm_address, 0);
    chk("mid_rst_rdata", r_dmem_data, 0);
    chk("mid_rst_err", bus_error, 0);
    r_req = 1'b0; avm_waitrequest = 1'b0;
    err_m = 1'b0; last_rd = '0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    do_read(32'h900, 32'h9999_AAAA, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
